// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and helpers for the multi-cycle mult/div unit.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam int c_max_w = 64;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MUL     = 3'd1,
        MD_DIV_RUN = 3'd2,
        MD_DIV_FIX = 3'd3,
        MD_DONE    = 3'd4
    } md_state_t;

    // Conditional two's-complement negate; the caller zero-extends and truncates.
    function automatic logic [c_max_w-1:0] abs_w(input logic [c_max_w-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_div_step
//  Description : One combinational restoring-division step on {rem, quo}.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // rem < divisor holds between steps, so the borrow bit alone decides the compare.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_fits  = ~w_diff[WIDTH];

    assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule : muldiv_div_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit (pipelined MUL, radix-2 DIV).
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  md_op_t             op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o
);

    localparam int c_cnt_w = $clog2(((WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY) + 1);
    localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_mul_cnt = c_cnt_w'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

    md_state_t          r_state;
    logic               r_busy;
    logic               r_valid;
    logic [2*WIDTH-1:0] r_result;
    logic               r_div_zero;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_q_neg;
    logic               r_r_neg;

    logic [1:0]         w_op;
    logic               w_signed;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_mul_tap;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_op     = op_i;
    assign w_signed = ~w_op[0];
    assign w_is_div = w_op[1];
    assign w_b_zero = (b_i == '0);
    assign w_a_neg  = w_signed & a_i[WIDTH-1];
    assign w_b_neg  = w_signed & b_i[WIDTH-1];

    // Extending to full product width makes the low half of one '*' correct for both signednesses.
    assign w_mul_a   = w_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign w_mul_b   = w_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign w_product = w_mul_a * w_mul_b;

    generate
        if (MUL_LATENCY > 1) begin : g_mul_pipe
            logic [2*WIDTH-1:0] r_mul_pipe [MUL_LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                        r_mul_pipe[i] <= '0;
                    end
                end else begin
                    r_mul_pipe[0] <= w_product;
                    for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                        r_mul_pipe[i] <= r_mul_pipe[i-1];
                    end
                end
            end

            assign w_mul_tap = r_mul_pipe[MUL_LATENCY-2];
        end else begin : g_mul_direct
            assign w_mul_tap = w_product;
        end
    endgenerate

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    assign w_rem_fix = WIDTH'(abs_w(c_max_w'(r_rem), r_r_neg));
    assign w_quo_fix = WIDTH'(abs_w(c_max_w'(r_quo), r_q_neg));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= MD_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (annul_i && (r_state != MD_IDLE)) begin
                r_state <= MD_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    MD_IDLE: begin
                        if (start_i && !annul_i) begin
                            r_busy <= 1'b1;
                            if (!w_is_div) begin
                                if (MUL_LATENCY == 1) begin
                                    r_state    <= MD_DONE;
                                    r_result   <= w_mul_tap;
                                    r_div_zero <= 1'b0;
                                    r_valid    <= 1'b1;
                                end else begin
                                    r_state <= MD_MUL;
                                    r_count <= c_mul_cnt;
                                end
                            end else if (w_b_zero) begin
                                r_state    <= MD_DONE;
                                r_result   <= {a_i, {WIDTH{1'b1}}};
                                r_div_zero <= 1'b1;
                                r_valid    <= 1'b1;
                            end else begin
                                r_state   <= MD_DIV_RUN;
                                r_count   <= c_div_cnt;
                                r_rem     <= '0;
                                r_quo     <= WIDTH'(abs_w(c_max_w'(a_i), w_a_neg));
                                r_divisor <= WIDTH'(abs_w(c_max_w'(b_i), w_b_neg));
                                r_q_neg   <= w_a_neg ^ w_b_neg;
                                r_r_neg   <= w_a_neg;
                            end
                        end
                    end
                    MD_MUL: begin
                        if (r_count == '0) begin
                            r_state    <= MD_DONE;
                            r_result   <= w_mul_tap;
                            r_div_zero <= 1'b0;
                            r_valid    <= 1'b1;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    MD_DIV_RUN: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_count == '0) begin
                            r_state <= MD_DIV_FIX;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    MD_DIV_FIX: begin
                        r_state    <= MD_DONE;
                        r_result   <= {w_rem_fix, w_quo_fix};
                        r_div_zero <= 1'b0;
                        r_valid    <= 1'b1;
                    end
                    MD_DONE: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A flush arriving during the DONE cycle must still squash the pulse.
    assign valid_o    = r_valid & ~annul_i;
    assign busy_o     = r_busy;
    assign result_o   = r_result;
    assign div_zero_o = r_div_zero;

endmodule : muldiv_unit
`default_nettype wire
